// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sizes and FSM state encoding for the ALU packet sequencer.
package alu_seq_pkg;

   localparam logic [7:0]  OP_ECHO    = 8'hEC;
   localparam logic [7:0]  OP_ADD     = 8'hA0;
   localparam logic [7:0]  OP_MUL     = 8'hA1;
   localparam logic [15:0] HDR_LEN    = 16'd4;
   localparam int          OPND_BYTES = 4;

   typedef enum logic [3:0] {
      HDR0,
      HDR1,
      HDR2,
      HDR3,
      ECHO,
      OPND,
      MWAIT,
      RESP,
      DRAIN
   } state_e;

endpackage

// File: rtl/byte_to_word32.sv
// Assembles four LSB-first bytes into a 32-bit word. The completed word and its
// valid pulse appear combinationally with the fourth byte so the caller can use it that cycle.
module byte_to_word32
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  count_q;
   logic [23:0] buf_q;

   assign word_o       = {byte_i, buf_q};
   assign word_valid_o = byte_valid_i && (count_q == 2'(OPND_BYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         buf_q   <= '0;
      end else if (clr_i) begin
         count_q <= '0;
         buf_q   <= '0;
      end else if (byte_valid_i) begin
         count_q <= count_q + 2'd1;
         buf_q   <= {byte_i, buf_q[23:8]};
      end
   end

endmodule

// File: rtl/alu_packet_sequencer.sv
// Parses UART command packets, echoes payloads or reduces 32-bit operands by add
// or external multiply, and streams the 4-byte little-endian result back out.
module alu_packet_sequencer
   import alu_seq_pkg::*;
#(
   parameter int         DATA_WIDTH_P = 8,
   parameter logic [7:0] OP_ECHO_P    = OP_ECHO,
   parameter logic [7:0] OP_ADD_P     = OP_ADD,
   parameter logic [7:0] OP_MUL_P     = OP_MUL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH_P-1:0] rx_tdata,
   input  logic                    rx_tvalid,
   output logic                    rx_tready,
   output logic [DATA_WIDTH_P-1:0] tx_tdata,
   output logic                    tx_tvalid,
   input  logic                    tx_tready,
   output logic [31:0]             mul_a_o,
   output logic [31:0]             mul_b_o,
   output logic                    mul_valid_o,
   input  logic                    mul_ready_i,
   input  logic [31:0]             mul_result_i,
   input  logic                    mul_result_valid_i,
   output logic                    busy_o,
   output logic                    err_o
);

   state_e      state_q;
   logic        started_q;
   logic [7:0]  opcode_q;
   logic [7:0]  len_lo_q;
   logic [15:0] rem_q;
   logic [31:0] acc_q;
   logic [31:0] opnd_q;
   logic        first_q;
   logic [1:0]  k_q;
   logic        mul_valid_q;
   logic        err_q;

   logic        rx_fire;
   logic        tx_fire;
   logic [15:0] hdr_len;
   logic [15:0] hdr_rem;
   logic        is_reduce;
   logic        last_byte;
   logic [31:0] word;
   logic        word_valid;
   logic [7:0]  resp_byte;

   assign rx_fire     = rx_tvalid && rx_tready;
   assign tx_fire     = tx_tvalid && tx_tready;
   assign hdr_len     = {rx_tdata, len_lo_q};
   assign hdr_rem     = hdr_len - HDR_LEN;
   assign is_reduce   = (opcode_q == OP_ADD_P) || (opcode_q == OP_MUL_P);
   assign last_byte   = (rem_q == 16'd1);
   assign resp_byte   = acc_q[{k_q, 3'b000} +: 8];

   assign mul_a_o     = acc_q;
   assign mul_b_o     = opnd_q;
   assign mul_valid_o = mul_valid_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != HDR0);

   byte_to_word32 u_asm (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (state_q == HDR0),
      .byte_valid_i ((state_q == OPND) && rx_fire),
      .byte_i       (rx_tdata),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   // started_q keeps rx_tready low until the first clock after reset release.
   always_comb begin
      rx_tready = 1'b0;
      tx_tvalid = 1'b0;
      tx_tdata  = '0;
      case (state_q)
         HDR0, HDR1, HDR2, HDR3: rx_tready = started_q;
         ECHO: begin
            rx_tready = tx_tready;
            tx_tvalid = rx_tvalid;
            tx_tdata  = rx_tdata;
         end
         OPND, DRAIN: rx_tready = 1'b1;
         RESP: begin
            tx_tvalid = 1'b1;
            tx_tdata  = resp_byte;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HDR0;
         started_q   <= 1'b0;
         opcode_q    <= '0;
         len_lo_q    <= '0;
         rem_q       <= '0;
         acc_q       <= '0;
         opnd_q      <= '0;
         first_q     <= 1'b0;
         k_q         <= '0;
         mul_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         started_q <= 1'b1;
         err_q     <= 1'b0;
         case (state_q)
            HDR0: if (rx_fire) begin
               opcode_q <= rx_tdata;
               state_q  <= HDR1;
            end
            HDR1: if (rx_fire) state_q <= HDR2;
            HDR2: if (rx_fire) begin
               len_lo_q <= rx_tdata;
               state_q  <= HDR3;
            end
            HDR3: if (rx_fire) begin
               rem_q   <= hdr_rem;
               first_q <= 1'b1;
               k_q     <= '0;
               if (hdr_len < HDR_LEN) begin
                  err_q   <= 1'b1;
                  state_q <= HDR0;
               end else if (opcode_q == OP_ECHO_P) begin
                  state_q <= (hdr_rem == 16'd0) ? HDR0 : ECHO;
               end else if (is_reduce && hdr_rem != 16'd0 && hdr_rem[1:0] == 2'b00) begin
                  state_q <= OPND;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= (hdr_rem == 16'd0) ? HDR0 : DRAIN;
               end
            end
            ECHO, DRAIN: if (rx_fire) begin
               rem_q <= rem_q - 16'd1;
               if (last_byte) state_q <= HDR0;
            end
            OPND: if (rx_fire) begin
               rem_q <= rem_q - 16'd1;
               if (word_valid) begin
                  if (first_q) begin
                     acc_q   <= word;
                     first_q <= 1'b0;
                     if (last_byte) state_q <= RESP;
                  end else if (opcode_q == OP_ADD_P) begin
                     acc_q <= acc_q + word;
                     if (last_byte) state_q <= RESP;
                  end else begin
                     opnd_q      <= word;
                     mul_valid_q <= 1'b1;
                     state_q     <= MWAIT;
                  end
               end
            end
            // A result pulse coinciding with the ready handshake is taken as-is.
            MWAIT: begin
               if (mul_ready_i) mul_valid_q <= 1'b0;
               if (mul_result_valid_i) begin
                  acc_q       <= mul_result_i;
                  mul_valid_q <= 1'b0;
                  state_q     <= (rem_q == 16'd0) ? RESP : OPND;
               end
            end
            RESP: if (tx_fire) begin
               k_q <= k_q + 2'd1;
               if (k_q == 2'd3) state_q <= HDR0;
            end
            default: state_q <= HDR0;
         endcase
      end
   end

endmodule
